slow_clock_meter: RTL and testbench
===================================

SLOW_CLOCK_METER -- requirements
Module: slow_clock_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle counter and the measurement outputs.
REQ-002 Parameter TIMEOUT, default 32'd900000000: clock_in cycles without a slow_in rising edge before the meter declares a stall.
REQ-003 clock_in  input  1: system clock (100 MHz); all logic is on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on clock_in rising edge.
REQ-005 slow_in  input  1: divided/slow clock under measurement; asynchronous to clock_in.
REQ-006 period_ack  input  1: consumer accepts the current result.
REQ-007 period_out  output  CNT_W: measured period in clock_in cycles (rise to rise).
REQ-008 high_out  output  CNT_W: measured high time in clock_in cycles (rise to fall).
REQ-009 period_valid  output  1: a result is held on period_out and high_out.
REQ-010 rise_pulse  output  1: one-cycle pulse per detected slow_in rising edge.
REQ-011 overrun  output  1: sticky; a result was lost because the previous one was not acknowledged.
REQ-012 stalled  output  1: no slow_in rising edge seen for TIMEOUT cycles.

Function
REQ-013 slow_in passes through a 2-flop synchronizer plus one history flop; edges are detected on the synchronized signal only.
REQ-014 rise_pulse is high for exactly one cycle, visible after the 2nd clock_in edge following the edge that first samples slow_in high.
REQ-015 FSM states: WAIT_FIRST (after reset, until the first rise) and MEASURE; the first rise moves WAIT_FIRST to MEASURE and produces no result.
REQ-016 In MEASURE, the counter clears on the rise cycle and increments once per cycle; it saturates at all-ones and never wraps.
REQ-017 On a synchronized fall in MEASURE, count+1 is latched as the pending high time; a fall in WAIT_FIRST is ignored.
REQ-018 On each rise in MEASURE, period = count+1 and the pending high time form one result, loaded in the same cycle rise_pulse asserts; period_valid is set in that cycle.
REQ-019 Saturated values are reported as all-ones.
REQ-020 Handshake: period_valid stays high, with outputs stable, until a cycle where period_valid and period_ack are both high; it then clears on the next edge.
REQ-021 New result while period_valid=1 and period_ack=0: outputs are not overwritten, the result is dropped, and overrun is set.
REQ-022 New result in the same cycle as an accepting ack: the new result loads, period_valid stays 1, and overrun is unchanged.
REQ-023 period_ack while period_valid=0 is ignored.

Reset
REQ-024 reset returns the FSM to WAIT_FIRST and clears the synchronizer, counter, pending high time, period_out, high_out, period_valid, rise_pulse, overrun and stalled to 0.
REQ-025 reset asserted mid-measurement discards the partial count; the first rise after reset produces no result.

Configuration
REQ-026 Macro SLOW_CLK_TIMEOUT_EN defined: a stall counter runs in both states and clears on every rise; stalled sets when it reaches TIMEOUT and clears on the next rise.
REQ-027 Macro SLOW_CLK_TIMEOUT_EN undefined: no stall counter or comparator is built, stalled is tied to 0, and the TIMEOUT parameter is unused.

Structure
REQ-028 Shared package slow_clk_pkg holds the FSM state enum (WAIT_FIRST, MEASURE) and the default CNT_W/TIMEOUT constants.
REQ-029 The synchronizer plus edge detector is one sub-module, sync_edge_detect, with outputs rise and fall; all other logic lives in slow_clock_meter.

Verification
REQ-030 slow_in period 10 cycles, 5 high / 5 low, ack tied 1 -> after the first rise, each rise gives period_out=10, high_out=5, with period_valid pulsing for 1 cycle.
REQ-031 Period 20, high 7, ack held 0 -> the first result (20/7) is held; the second rise sets overrun=1 and the outputs remain 20/7.
REQ-032 Ack asserted exactly in the next-rise cycle -> the new result loads, period_valid stays 1, and overrun stays 0.
REQ-033 CNT_W=8, slow_in period 300 -> period_out=255 (saturated), no wrap.
REQ-034 SLOW_CLK_TIMEOUT_EN defined, TIMEOUT=100, slow_in held low -> stalled=1 after 100 cycles; the next rise clears it. Macro undefined -> stalled stays 0.
REQ-035 reset pulsed mid-period -> all outputs are 0; the first rise after reset produces no result, and the second rise produces a correct period.

Source files
------------

// File: rtl/slow_clk_pkg.sv
// slow_clk_pkg: shared FSM states and default sizing for slow_clock_meter
package slow_clk_pkg;
  typedef enum logic {WAIT_FIRST, MEASURE} state_t;
  localparam int DEF_CNT_W = 32;
  localparam logic [31:0] DEF_TIMEOUT = 32'd900000000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus history flop with rise/fall strobes
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] sync;
  always_ff @(posedge clock_in)
    sync <= reset ? 3'b000 : {sync[1:0], d};
  // sync[0] may be metastable; edges are taken only from sync[1] vs sync[2]
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
endmodule

// File: rtl/slow_clock_meter.sv
// slow_clock_meter: measures period and high time of slow_in in clock_in cycles.
// Define SLOW_CLK_TIMEOUT_EN to build the stall detector.
module slow_clock_meter
  import slow_clk_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             slow_in,
  input  logic             period_ack,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             rise_pulse,
  output logic             overrun,
  output logic             stalled
);
  state_t state, state_nxt;
  logic rise, fall, result;
  logic [CNT_W-1:0] count, count_inc, high_pend;
  sync_edge_detect u_sync (
    .clock_in(clock_in),
    .reset(reset),
    .d(slow_in),
    .rise(rise),
    .fall(fall)
  );
  assign count_inc = &count ? count : count + 1'b1;
  assign result = rise && state == MEASURE;
  always_ff @(posedge clock_in)
    state <= reset ? WAIT_FIRST : state_nxt;
  always_comb state_nxt = rise ? MEASURE : state;
  always_ff @(posedge clock_in)
    if (reset) begin
      count        <= '0;
      high_pend    <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      rise_pulse   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rise_pulse <= rise;
      count      <= rise ? '0 : state == MEASURE ? count_inc : count;
      if (fall && state == MEASURE) high_pend <= count_inc;
      // an accepting ack frees the slot in the same cycle a new result arrives
      if (result && (!period_valid || period_ack)) begin
        period_out   <= count_inc;
        high_out     <= high_pend;
        period_valid <= 1'b1;
      end else if (result) overrun <= 1'b1;
      else if (period_ack) period_valid <= 1'b0;
    end
`ifdef SLOW_CLK_TIMEOUT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clock_in)
    if (reset) begin
      stall_cnt <= '0;
      stalled   <= 1'b0;
    end else begin
      stall_cnt <= rise ? '0 : stalled ? stall_cnt : stall_cnt + 1'b1;
      stalled   <= !rise && (stalled || stall_cnt == TIMEOUT - 1'b1);
    end
`else
  assign stalled = 1'b0;
`endif
endmodule

// File: tb/tb_slow_clock_meter.sv
// tb_slow_clock_meter: randomized bench for slow_clock_meter against an edge-timestamp model.
// Honours SLOW_CLK_TIMEOUT_EN to match the DUT build.
module tb_slow_clock_meter;
  localparam int TMO = 100;
`ifdef SLOW_CLK_TIMEOUT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, slow_in = 1'b0, period_ack = 1'b0;
  logic [7:0] period_out, high_out;
  logic period_valid, rise_pulse, overrun, stalled;
  int vectors = 0, miscompares = 0;
  bit wave_on = 1'b0, ack_rand = 1'b0;
  int per_len = 10, high_len = 5, phase = 0;
  slow_clock_meter #(.CNT_W(8), .TIMEOUT(TMO)) u_dut (
    .clock_in(clk),
    .reset(reset),
    .slow_in(slow_in),
    .period_ack(period_ack),
    .period_out(period_out),
    .high_out(high_out),
    .period_valid(period_valid),
    .rise_pulse(rise_pulse),
    .overrun(overrun),
    .stalled(stalled)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // waveform and random-ack generator
  initial forever begin
    @(negedge clk);
    if (wave_on) begin
      slow_in = phase < high_len;
      phase = phase + 1 >= per_len ? 0 : phase + 1;
    end
    if (ack_rand) period_ack = $urandom_range(0, 2) == 0;
  end
  // model: events are timestamped by edge number; results are timestamp differences
  int edge_n = 0, last_rise = 0, stall_ref = 0, pend = 0;
  logic [3:0] hist = '0;
  bit armed = 0, live = 0, m_valid = 0, m_rp = 0, m_ovr = 0, m_stall = 0;
  int m_period = 0, m_high = 0;
  function automatic int sat(input int v);
    return v > 255 ? 255 : v;
  endfunction
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (reset) begin
      hist = '0; armed = 0; pend = 0; m_period = 0; m_high = 0;
      m_valid = 0; m_rp = 0; m_ovr = 0; m_stall = 0;
      stall_ref = edge_n; last_rise = edge_n; live = 1;
    end else begin
      automatic bit r, f;
      hist = {hist[2:0], slow_in};
      r = hist[2] & ~hist[3];
      f = ~hist[2] & hist[3];
      m_rp = r;
      if (f && armed) pend = sat(edge_n - last_rise);
      if (r && armed) begin
        if (!m_valid || period_ack) begin
          m_period = sat(edge_n - last_rise);
          m_high = pend;
          m_valid = 1;
        end else m_ovr = 1;
      end else if (period_ack) m_valid = 0;
      if (r) begin
        armed = 1;
        last_rise = edge_n;
        stall_ref = edge_n;
      end
      m_stall = STALL_EN && !r && (edge_n - stall_ref >= TMO);
    end
    #1;
    if (live) begin
      chk("period_out", period_out, m_period);
      chk("high_out", high_out, m_high);
      chk("period_valid", period_valid, m_valid);
      chk("rise_pulse", rise_pulse, m_rp);
      chk("overrun", overrun, m_ovr);
      chk("stalled", stalled, m_stall);
    end
  end
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic start_wave(input int p, input int h, input bit ack);
    wave_on = 1'b0; ack_rand = 1'b0; slow_in = 1'b0; period_ack = ack;
    per_len = p; high_len = h; phase = 0;
    do_reset(2);
    wave_on = 1'b1;
  endtask
  task automatic wait_valid(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (period_valid) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask
  initial begin
    do_reset(3);
    chk("rst_period", period_out, 0);
    chk("rst_high", high_out, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_stalled", stalled, 0);
    start_wave(10, 5, 1'b1);
    wait_valid("p10", 60);
    chk("p10_period", period_out, 10);
    chk("p10_high", high_out, 5);
    @(negedge clk);
    chk("p10_pulse", period_valid, 0);
    repeat (40) @(negedge clk);
    start_wave(20, 7, 1'b0);
    wait_valid("p20", 100);
    chk("p20_period", period_out, 20);
    chk("p20_high", high_out, 7);
    chk("p20_no_ovr", overrun, 0);
    repeat (22) @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_period", period_out, 20);
    chk("ovr_high", high_out, 7);
    start_wave(20, 7, 1'b0);
    wait_valid("race", 100);
    repeat (19) @(negedge clk);
    period_ack = 1'b1;
    @(negedge clk);
    period_ack = 1'b0;
    chk("race_valid", period_valid, 1);
    chk("race_rise", rise_pulse, 1);
    chk("race_ovr", overrun, 0);
    start_wave(300, 150, 1'b1);
    wait_valid("sat", 800);
    chk("sat_period", period_out, 255);
    chk("sat_high", high_out, 150);
    wave_on = 1'b0; slow_in = 1'b0;
    do_reset(1);
    repeat (99) @(negedge clk);
    chk("stall_99", stalled, 0);
    @(negedge clk);
    chk("stall_100", stalled, STALL_EN);
    slow_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_rise", rise_pulse, 1);
    chk("stall_clear", stalled, 0);
    start_wave(16, 8, 1'b1);
    repeat (50) @(negedge clk);
    while (slow_in) @(negedge clk);
    repeat (2) @(negedge clk);
    do_reset(1);
    chk("mid_period", period_out, 0);
    chk("mid_high", high_out, 0);
    chk("mid_valid", period_valid, 0);
    chk("mid_rise", rise_pulse, 0);
    wait_valid("mid", 60);
    chk("mid_second", period_out, 16);
    chk("mid_second_high", high_out, 8);
    for (int k = 0; k < 12; k++) begin
      automatic int p = $urandom_range(3, 70);
      automatic int h = $urandom_range(1, p - 1);
      start_wave(p, h, 1'b0);
      ack_rand = 1'b1;
      repeat ($urandom_range(2, 5) * p) @(negedge clk);
      if ($urandom_range(0, 2) == 0) do_reset(1);
      repeat ($urandom_range(2, 4) * p) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
